// File: rtl/phase_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// phase_bank_ctrl_if : byte-stream command/reply handshake bundle
// Rev 1.0
// ============================================================================
interface phase_bank_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/phase_bank_ctrl.sv
`default_nettype none
// ============================================================================
// phase_bank_ctrl : command-driven double-buffered phase/duty table,
//                   shadow bank committed on sync_clk rising edges
// Rev 1.0
// ============================================================================
module phase_bank_ctrl #(
    parameter int OUTPUTS      = 88,
    parameter int OFFSET_WIDTH = 11,
    parameter int DUTY_WIDTH   = 8
) (
    input  wire logic                                  clk,
    input  wire logic                                  rst,
    input  wire logic                                  sync_clk_i,
    phase_bank_ctrl_if.slave                           bus,
    output logic [OUTPUTS*(OFFSET_WIDTH+1)-1:0]        phase_out_o,
    output logic [OUTPUTS*DUTY_WIDTH-1:0]              duty_out_o,
    output logic                                       reload_n_o,
    output logic                                       armed_o
);
    localparam int c_pw   = OFFSET_WIDTH + 1;
    localparam int c_ch_w = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam logic [DUTY_WIDTH-1:0] c_duty_rst = DUTY_WIDTH'(1) << (DUTY_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_B1, S_B2, S_B3, S_EXEC} state_t;

    state_t                 state_q, state_d;
    logic [6:0]             b0_q, b1_q, b2_q, b3_q;
    logic                   sync_q, armed_q, armed_d, reload_n_q;
    logic                   tx_valid_q;
    logic [7:0]             tx_data_q, err_cnt_q, err_cnt_d;
    logic [c_pw-1:0]        sh_phase_q  [OUTPUTS];
    logic [c_pw-1:0]        act_phase_q [OUTPUTS];
    logic [DUTY_WIDTH-1:0]  sh_duty_q   [OUTPUTS];
    logic [DUTY_WIDTH-1:0]  act_duty_q  [OUTPUTS];

    logic                   w_rx_ready, w_rx_fire, w_restart_err;
    logic [2:0]             w_op, w_sum;
    logic [7:0]             w_ch, w_reply;
    logic [13:0]            w_v;
    logic                   w_exec, w_ch_ok, w_cmd_err, w_do, w_commit;
    logic [c_ch_w-1:0]      w_ch_idx;

    assign w_rx_ready = !tx_valid_q && (state_q != S_EXEC);
    assign w_rx_fire  = bus.rx_valid && w_rx_ready;

    // Frame fields as captured; only the low three checksum bits matter (mod 8).
    assign w_op     = b0_q[6:4];
    assign w_ch     = {b0_q[3:0], b1_q[6:3]};
    assign w_v      = {b1_q[2:0], b2_q, b3_q[6:3]};
    assign w_sum    = b0_q[2:0] + b1_q[2:0] + b2_q[2:0] + b3_q[5:3];
    assign w_ch_idx = w_ch[c_ch_w-1:0];
    assign w_ch_ok  = ({1'b0, w_ch} < 9'(OUTPUTS));
    assign w_exec   = (state_q == S_EXEC);
    assign w_cmd_err = w_exec && ((w_sum != b3_q[2:0]) || (w_op == 3'd7) ||
                                  ((w_op <= 3'd1) && !w_ch_ok));
    assign w_do     = w_exec && !w_cmd_err;
    assign w_commit = sync_clk_i && !sync_q && armed_q;

    always_comb begin
        w_reply = 8'hFF;
        case (w_v)
            14'd0:   w_reply = 8'(OUTPUTS - 1);
            14'd1:   w_reply = err_cnt_q;
            14'd2:   w_reply = {armed_q, 7'd0};
            default: w_reply = 8'hFF;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        w_restart_err = 1'b0;
        case (state_q)
            S_IDLE: if (w_rx_fire && bus.rx_data[7]) state_d = S_B1;
            S_B1, S_B2, S_B3: begin
                if (w_rx_fire) begin
                    if (bus.rx_data[7]) begin
                        state_d       = S_B1;
                        w_restart_err = 1'b1;
                    end else if (state_q == S_B1) begin
                        state_d = S_B2;
                    end else if (state_q == S_B2) begin
                        state_d = S_B3;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        armed_d   = armed_q;
        err_cnt_d = err_cnt_q;
        if (w_commit) armed_d = 1'b0;
        // A SWAP landing on a commit re-arms for the next sync edge.
        if (w_do && (w_op == 3'd2)) armed_d = 1'b1;
        if (w_do && (w_op == 3'd6)) begin
            err_cnt_d = 8'd0;
        end else if ((w_restart_err || w_cmd_err) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            b3_q       <= '0;
            sync_q     <= 1'b0;
            armed_q    <= 1'b1;
            reload_n_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_clk_i;
            armed_q    <= armed_d;
            reload_n_q <= !w_commit;
            err_cnt_q  <= err_cnt_d;
            if (w_rx_fire) begin
                if (bus.rx_data[7])       b0_q <= bus.rx_data[6:0];
                else if (state_q == S_B1) b1_q <= bus.rx_data[6:0];
                else if (state_q == S_B2) b2_q <= bus.rx_data[6:0];
                else if (state_q == S_B3) b3_q <= bus.rx_data[6:0];
            end
            if (w_do && (w_op == 3'd3)) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= w_reply;
            end else if (tx_valid_q && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    // Non-blocking semantics make a same-cycle commit copy the pre-write shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUTPUTS; i++) begin
                sh_phase_q[i]  <= '0;
                act_phase_q[i] <= '0;
                sh_duty_q[i]   <= c_duty_rst;
                act_duty_q[i]  <= c_duty_rst;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < OUTPUTS; i++) begin
                    act_phase_q[i] <= sh_phase_q[i];
                    act_duty_q[i]  <= sh_duty_q[i];
                end
            end
            if (w_do) begin
                case (w_op)
                    3'd0: sh_phase_q[w_ch_idx] <= {w_v[13], w_v[OFFSET_WIDTH-1:0]};
                    3'd1: sh_duty_q[w_ch_idx]  <= w_v[DUTY_WIDTH-1:0];
                    3'd4: for (int i = 0; i < OUTPUTS; i++)
                              sh_phase_q[i] <= {w_v[13], w_v[OFFSET_WIDTH-1:0]};
                    3'd5: for (int i = 0; i < OUTPUTS; i++)
                              sh_duty_q[i] <= w_v[DUTY_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < OUTPUTS; g++) begin : g_pack
            assign phase_out_o[c_pw*g +: c_pw]             = act_phase_q[g];
            assign duty_out_o[DUTY_WIDTH*g +: DUTY_WIDTH]  = act_duty_q[g];
        end
    endgenerate

    assign bus.rx_ready = w_rx_ready;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign reload_n_o   = reload_n_q;
    assign armed_o      = armed_q;
endmodule
`default_nettype wire

// File: tb/tb_phase_bank_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_phase_bank_ctrl : directed self-checking bench for phase_bank_ctrl
// Rev 1.0
// ============================================================================
module tb_phase_bank_ctrl;
    localparam int N  = 88;
    localparam int PW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sync_clk = 1'b0;
    logic [N*PW-1:0] phase_out;
    logic [N*DW-1:0] duty_out;
    logic reload_n, armed;

    phase_bank_ctrl_if bus();

    phase_bank_ctrl #(.OUTPUTS(N), .OFFSET_WIDTH(11), .DUTY_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_clk_i  (sync_clk),
        .bus         (bus),
        .phase_out_o (phase_out),
        .duty_out_o  (duty_out),
        .reload_n_o  (reload_n),
        .armed_o     (armed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] sh_ph [N];
    logic [PW-1:0] act_ph[N];
    logic [DW-1:0] sh_du [N];
    logic [DW-1:0] act_du[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_frame(input logic [2:0] op, input logic [7:0] ch,
                                             input logic [13:0] v, input logic bad);
        logic [7:0] b0, b1, b2, b3;
        logic [9:0] s;
        b0 = {1'b1, op, ch[7:4]};
        b1 = {1'b0, ch[3:0], v[13:11]};
        b2 = {1'b0, v[10:4]};
        s  = 10'(b0[6:0]) + 10'(b1[6:0]) + 10'(b2[6:0]) + 10'(v[3:0]);
        b3 = {1'b0, v[3:0], s[2:0] ^ {2'b00, bad}};
        return {b0, b1, b2, b3};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.rx_ready) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [31:0] f);
        send_byte(f[31:24]);
        send_byte(f[23:16]);
        send_byte(f[15:8]);
        send_byte(f[7:0]);
    endtask

    // Returns after the EXEC cycle has completed.
    task automatic send_frame(input logic [2:0] op, input logic [7:0] ch,
                              input logic [13:0] v, input logic bad);
        send_bytes(mk_frame(op, ch, v, bad));
        tick();
    endtask

    task automatic query(input logic [13:0] v, input logic [7:0] exp, input string tag);
        send_frame(3'd3, 8'd0, v, 1'b0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd1);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'(exp));
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check({tag, "_tx_clear"}, 32'(bus.tx_valid), 32'd0);
    endtask

    task automatic check_banks(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (phase_out[PW*i +: PW] !== act_ph[i]) bad++;
            if (duty_out[DW*i +: DW] !== act_du[i]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_commit(input string tag);
        sync_clk = 1'b1;
        check({tag, "_pre_reload"}, 32'(reload_n), 32'd1);
        tick();
        check({tag, "_reload_low"}, 32'(reload_n), 32'd0);
        check({tag, "_disarmed"}, 32'(armed), 32'd0);
        for (int i = 0; i < N; i++) begin
            act_ph[i] = sh_ph[i];
            act_du[i] = sh_du[i];
        end
        tick();
        check({tag, "_reload_high"}, 32'(reload_n), 32'd1);
        sync_clk = 1'b0;
        tick();
        tick();
        check_banks({tag, "_banks"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            sh_ph[i] = '0; act_ph[i] = '0;
            sh_du[i] = 8'h80; act_du[i] = 8'h80;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("rst_reload_n", 32'(reload_n), 32'd1);
        check("rst_armed", 32'(armed), 32'd1);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check_banks("rst_banks");
        do_commit("first_commit");
        tick();
        check("one_pulse_only", 32'(reload_n), 32'd1);

        // Shadow writes stay invisible until swap + sync edge
        send_frame(3'd0, 8'd5, 14'h212C, 1'b0);
        sh_ph[5] = 12'h92C;
        send_frame(3'd1, 8'd10, 14'h0033, 1'b0);
        sh_du[10] = 8'h33;
        check_banks("pre_swap_banks");
        check("pre_swap_armed", 32'(armed), 32'd0);
        send_frame(3'd2, 8'd0, 14'd0, 1'b0);
        check("swap_armed", 32'(armed), 32'd1);
        send_frame(3'd2, 8'd0, 14'd0, 1'b0);
        query(14'd2, 8'h80, "q_armed");
        check_banks("armed_no_sync_banks");
        do_commit("ch5_commit");
        check("ch5_slice", 32'(phase_out[PW*5 +: PW]), 32'h92C);

        // Bad checksum, error count, clear
        send_frame(3'd1, 8'd3, 14'h0011, 1'b1);
        query(14'd1, 8'd1, "q_err_chk");
        send_frame(3'd6, 8'd0, 14'd0, 1'b0);
        query(14'd1, 8'd0, "q_err_clr");
        query(14'd9, 8'hFF, "q_other");

        // Aborted partial frame, then a full valid frame
        f = mk_frame(3'd1, 8'd9, 14'h0099, 1'b0);
        send_byte(f[31:24]);
        send_byte(f[23:16]);
        send_frame(3'd1, 8'd7, 14'h0044, 1'b0);
        sh_du[7] = 8'h44;
        query(14'd1, 8'd1, "q_err_restart");
        send_frame(3'd0, 8'd200, 14'h0001, 1'b0);
        query(14'd1, 8'd2, "q_err_range");
        send_frame(3'd7, 8'd0, 14'd0, 1'b0);
        query(14'd1, 8'd3, "q_err_op7");
        send_frame(3'd2, 8'd0, 14'd0, 1'b0);
        do_commit("err_commit");
        send_frame(3'd6, 8'd0, 14'd0, 1'b0);

        // Reply back-pressure blocks the receiver
        send_frame(3'd3, 8'd0, 14'd0, 1'b0);
        f = mk_frame(3'd5, 8'd0, 14'h005A, 1'b0);
        bus.rx_data  = f[31:24];
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rx_ready", 32'(bus.rx_ready), 32'd0);
        end
        check("hold_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("hold_tx_data", 32'(bus.tx_data), 32'd87);
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("release_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("release_rx_ready", 32'(bus.rx_ready), 32'd1);
        send_frame(3'd5, 8'd0, 14'h005A, 1'b0);
        for (int i = 0; i < N; i++) sh_du[i] = 8'h5A;
        query(14'd1, 8'd0, "q_err_hold");
        send_frame(3'd4, 8'd0, 14'h2007, 1'b0);
        for (int i = 0; i < N; i++) sh_ph[i] = 12'h807;
        send_frame(3'd2, 8'd0, 14'd0, 1'b0);
        do_commit("all_commit");

        // SWAP executing on the very cycle of a committing sync edge
        send_frame(3'd0, 8'd0, 14'h0005, 1'b0);
        sh_ph[0] = 12'h005;
        send_frame(3'd2, 8'd0, 14'd0, 1'b0);
        send_bytes(mk_frame(3'd2, 8'd0, 14'd0, 1'b0));
        sync_clk = 1'b1;
        tick();
        check("race_reload_low", 32'(reload_n), 32'd0);
        check("race_armed", 32'(armed), 32'd1);
        for (int i = 0; i < N; i++) begin
            act_ph[i] = sh_ph[i];
            act_du[i] = sh_du[i];
        end
        tick();
        check("race_reload_high", 32'(reload_n), 32'd1);
        tick();
        check("race_sync_high", 32'(reload_n), 32'd1);
        sync_clk = 1'b0;
        tick();
        tick();
        check_banks("race_banks");
        check("race_ch0", 32'(phase_out[PW*0 +: PW]), 32'h005);
        do_commit("race_second");
        query(14'd2, 8'h00, "q_disarmed");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/phase_bank_ctrl.md
# phase_bank_ctrl

Command-driven, double-buffered phase/duty table for the transducer array. It sits between the UART byte streams and the per-channel clock generators. A checksummed 4-byte command protocol writes a shadow bank of per-channel phase offsets, enables and duty values. The shadow bank is copied to the active bank, with a one-cycle reload strobe, only on a rising edge of the array sync clock, so every channel changes phase in the same carrier period.

## Interface
- OUTPUTS, 88, number of channels; legal range 1–256.
- OFFSET_WIDTH, 11, phase offset bits per channel; legal range 1–13.
- DUTY_WIDTH, 8, duty bits per channel; legal range 1–14.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- sync_clk  in  1  zero-phase array clock, generated synchronously in the clk domain.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready.
- tx_data  out  8  reply byte.
- tx_valid  out  1  reply pending.
- tx_ready  in  1  reply consumed when tx_valid & tx_ready.
- phase_out  out  OUTPUTS*(OFFSET_WIDTH+1)  active bank; channel i occupies slice [(OFFSET_WIDTH+1)*i +: OFFSET_WIDTH+1] as {enable, offset}.
- duty_out  out  OUTPUTS*DUTY_WIDTH  active duty values; channel i occupies [DUTY_WIDTH*i +: DUTY_WIDTH].
- reload_n  out  1  one-cycle low pulse that coincides with an active-bank update.
- armed  out  1  swap pending.

## Operation
- Frame format, 4 bytes: b0={1,op[2:0],ch[7:4]}, b1={0,ch[3:0],V[13:11]}, b2={0,V[10:4]}, b3={0,V[3:0],chk[2:0]}.
- Checksum: chk = (b0[6:0]+b1[6:0]+b2[6:0]+b3[6:3]) mod 8.
- Receive FSM states: IDLE, B1, B2, B3, EXEC.
  - In any state, a byte with MSB=1 restarts the frame at B1. If a partial frame was discarded, err_cnt increments.
  - A byte with MSB=0 in IDLE is dropped silently.
  - After b3, the FSM enters EXEC for one cycle. rx_ready=0 in EXEC.
- Command errors: a checksum mismatch, ch≥OUTPUTS on ops 0/1, or op 7 each increments err_cnt and is not executed.
- Op 0 SET_PHASE: shadow[ch] ← {V[13], V[OFFSET_WIDTH-1:0]}.
- Op 1 SET_DUTY: shadow_duty[ch] ← V[DUTY_WIDTH-1:0].
- Op 2 SWAP: armed ← 1. A second SWAP while already armed has no additional effect.
- Op 3 QUERY: loads one reply byte and sets tx_valid.
  - V=0: OUTPUTS-1, in 8 bits.
  - V=1: err_cnt.
  - V=2: {armed, 7'd0}.
  - Any other V: 8'hFF.
- Op 4 SET_ALL_PHASE: every channel's shadow entry ← {V[13], offset}.
- Op 5 SET_ALL_DUTY: every channel's shadow duty ← V[DUTY_WIDTH-1:0].
- Op 6 CLEAR_ERR: err_cnt ← 0.
- err_cnt: 8 bits, saturates at 255.
- Commit: on the cycle where sync_clk=1 and sync_q=0 and armed=1 (sync_q is sync_clk registered), the following happens at the next clk edge:
  - active banks ← shadow banks;
  - armed ← 0;
  - reload_n ← 0 for that one cycle.
- Simultaneous events:
  - Commit and a shadow write in the same cycle: the commit copies the pre-write shadow; the write lands in shadow only.
  - Commit and a SWAP in EXEC in the same cycle: armed ends at 1, so the next sync edge commits again.
- rx_ready = !tx_valid && state≠EXEC. While a reply is pending, no bytes are accepted.
- Reset values:
  - phase_out and shadow = 0 (all channels disabled).
  - duty_out and shadow duty = 2^(DUTY_WIDTH-1).
  - armed=1, so the first sync edge after reset commits.
  - reload_n=1, tx_valid=0, tx_data=0, err_cnt=0, FSM in IDLE, sync_q=0.
- Reset mid-frame discards the partial frame without counting an error.

## Timing
- Byte acceptance is one per cycle while rx_ready=1.
- Last byte accepted in cycle n → FSM in EXEC in cycle n+1 → shadow updated, or tx_valid=1, at the edge ending cycle n+1.
- Commit latency: reload_n is low and phase_out/duty_out are updated in the cycle after the sync_clk rising edge.
- reload_n is never low for more than one cycle. There is at most one commit per sync period.
- tx_valid stays high until tx_ready. It clears at the edge where both are high; rx_ready rises in the same edge.
- All outputs are registered. There is no combinational path from rx or tx inputs to outputs, except rx_ready, which depends only on registered state.

## Test plan
- Reset, then toggle sync_clk:
  - before commit: phase_out=0, duty_out=0x80 on every channel;
  - on the first rising edge: reload_n low for exactly one cycle, armed→0.
- SET_PHASE to ch=5 with V={1,offset 300}, then SWAP:
  - phase_out slice 5 stays unchanged until the next sync edge, then becomes {1,11'd300};
  - other channels stay 0.
- Corrupt chk on a SET_DUTY frame:
  - no shadow change;
  - QUERY V=1 returns 1;
  - CLEAR_ERR followed by QUERY V=1 returns 0.
- Send b0, b1, then a new b0 and a full valid frame:
  - err_cnt=1;
  - the second frame executes.
  - Also send ch=200 with OUTPUTS=88: err_cnt increments.
- QUERY V=0 with tx_ready held low for 10 cycles:
  - tx_data=87, tx_valid held;
  - rx_ready=0 throughout and bytes offered are not consumed;
  - after tx_ready, the next frame is accepted.
- Issue SWAP in EXEC in the exact cycle of a sync rising edge with armed=1:
  - the commit occurs;
  - armed=1 afterwards;
  - a second reload_n pulse occurs at the following sync edge.
